// File: rtl/vx_tcu_drl_acc_seq_if.sv
// Handshake and datapath bundle between the FEDP accumulation sequencer and its
// job source, product stream, DRL accumulator and result sink.
interface vx_tcu_drl_acc_seq_if #(
  parameter int N  = 5,
  parameter int WI = 26,
  parameter int WO = 30,
  parameter int KW = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic [KW-1:0]     req_len;
  logic [31:0]       req_id;
  logic [WI-1:0]     req_c;
  logic              req_c_sticky;

  logic              step_valid;
  logic              step_ready;
  logic [(N-1)*WI-1:0] step_sigs;
  logic [N-2:0]      step_sticky;

  logic              acc_valid;
  logic [31:0]       acc_req_id;
  logic [N-2:0]      acc_lane_mask;
  logic [N*WI-1:0]   acc_sigs;
  logic [N-1:0]      acc_sticky;
  logic [WO-1:0]     acc_sig_out;
  logic              acc_sticky_in;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [WO-1:0]     rsp_sig;
  logic              rsp_sticky;
  logic [31:0]       rsp_id;

  modport slave (
    input  req_valid, req_len, req_id, req_c, req_c_sticky,
    output req_ready,
    input  step_valid, step_sigs, step_sticky,
    output step_ready,
    output acc_valid, acc_req_id, acc_lane_mask, acc_sigs, acc_sticky,
    input  acc_sig_out, acc_sticky_in,
    output rsp_valid, rsp_sig, rsp_sticky, rsp_id,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_len, req_id, req_c, req_c_sticky,
    input  req_ready,
    output step_valid, step_sigs, step_sticky,
    input  step_ready,
    input  acc_valid, acc_req_id, acc_lane_mask, acc_sigs, acc_sticky,
    output acc_sig_out, acc_sticky_in,
    input  rsp_valid, rsp_sig, rsp_sticky, rsp_id,
    output rsp_ready
  );
endinterface

// File: rtl/vx_tcu_drl_acc_seq.sv
// Sequences one FEDP dot-product job as a series of (N-1)-lane steps through the
// DRL accumulator, keeping the running WO-bit sum and sticky, one result per job.
//
// state | meaning
// IDLE  | waiting for a job, req_ready high
// RUN   | streaming product steps into the accumulator
// DONE  | result held on rsp_* until accepted
module vx_tcu_drl_acc_seq #(
  parameter int N  = 5,
  parameter int WI = 26,
  parameter int WO = 30,
  parameter int KW = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  vx_tcu_drl_acc_seq_if.slave bus
);
  localparam int L = N - 1;
  localparam logic [KW-1:0] LANES = KW'(L);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [WO-1:0] sum_q;
  logic          sticky_q;
  logic [KW-1:0] rem_q;
  logic [31:0]   id_q;

  logic          req_fire, step_fire, last_step;
  logic [KW-1:0] rem_dec;
  logic [L-1:0]  lane_mask;

  assign req_fire  = (state_q == IDLE) && bus.req_valid;
  assign step_fire = (state_q == RUN) && bus.step_valid;
  assign last_step = (rem_q <= LANES);
  // Tail step consumes only what is left so rem never wraps below zero.
  assign rem_dec   = last_step ? rem_q : LANES;

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < L; i++) lane_mask[i] = (rem_q > KW'(i));
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.step_ready = 1'b0;
    bus.acc_valid  = 1'b0;
    bus.rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = (bus.req_len == '0) ? DONE : RUN;
      end
      RUN: begin
        bus.step_ready = 1'b1;
        bus.acc_valid  = bus.step_valid;
        if (bus.step_valid && last_step) state_d = DONE;
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  assign bus.acc_req_id    = id_q;
  assign bus.acc_lane_mask = lane_mask;
  assign bus.acc_sigs      = {{WI{1'b0}}, bus.step_sigs};
  assign bus.acc_sticky    = {1'b0, bus.step_sticky};
  assign bus.rsp_sig       = sum_q;
  assign bus.rsp_sticky    = sticky_q;
  assign bus.rsp_id        = id_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sum_q    <= '0;
      sticky_q <= 1'b0;
      rem_q    <= '0;
      id_q     <= '0;
    end else begin
      state_q <= state_d;
      // A flushed job's partial state is simply abandoned; the next req reloads it.
      if (!flush) begin
        if (req_fire) begin
          sum_q    <= {{(WO-WI){bus.req_c[WI-1]}}, bus.req_c};
          sticky_q <= bus.req_c_sticky;
          id_q     <= bus.req_id;
          rem_q    <= bus.req_len;
        end
        if (step_fire) begin
          sum_q    <= sum_q + bus.acc_sig_out;
          sticky_q <= sticky_q | bus.acc_sticky_in;
          rem_q    <= rem_q - rem_dec;
        end
      end
    end
  end

  a_step_only_in_run: assert property (@(posedge clk) disable iff (!reset_n)
    (bus.step_valid && bus.step_ready) |-> (state_q == RUN));
  a_mask_nonzero: assert property (@(posedge clk) disable iff (!reset_n)
    bus.acc_valid |-> (bus.acc_lane_mask != '0));
endmodule

// File: tb/tb_vx_tcu_drl_acc_seq.sv
// Directed bench for vx_tcu_drl_acc_seq with a behavioural accumulator and a
// result scoreboard filled from the stimulus.
module tb_vx_tcu_drl_acc_seq;
  localparam int N = 5, WI = 26, WO = 30, KW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;

  vx_tcu_drl_acc_seq_if #(.N(N), .WI(WI), .WO(WO), .KW(KW)) bus ();

  vx_tcu_drl_acc_seq #(.N(N), .WI(WI), .WO(WO), .KW(KW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  // Accumulator model: masked sum of the product lanes, C slot contributes nothing.
  always_comb begin
    logic [WO-1:0] acc;
    logic [WI-1:0] lane;
    acc = '0;
    for (int i = 0; i < N-1; i++) begin
      lane = bus.acc_sigs[i*WI +: WI];
      if (bus.acc_lane_mask[i]) acc = acc + {{(WO-WI){lane[WI-1]}}, lane};
    end
    bus.acc_sig_out   = acc;
    bus.acc_sticky_in = |(bus.acc_sticky[N-2:0] & bus.acc_lane_mask);
  end

  typedef struct {
    logic [WO-1:0] sig;
    logic          sticky;
    logic [31:0]   id;
  } rsp_t;

  rsp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-2:0] mask_for(input int rem);
    case (rem)
      1: return 4'b0001;
      2: return 4'b0011;
      3: return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic send_req(input int len, input logic [WI-1:0] c, input logic cs, input logic [31:0] id);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_len = KW'(len); bus.req_c = c;
    bus.req_c_sticky = cs; bus.req_id = id;
    #1 chk("req_ready_idle", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
  endtask

  task automatic drive_step(input logic [WI-1:0] prod, input logic [N-2:0] stky,
                            input logic [N-2:0] exp_mask, input logic [31:0] id);
    bus.step_valid = 1'b1;
    bus.step_sigs  = {(N-1){prod}};
    bus.step_sticky = stky;
    #1;
    chk("step_ready", bus.step_ready, 1);
    chk("acc_valid", bus.acc_valid, 1);
    chk("acc_lane_mask", bus.acc_lane_mask, exp_mask);
    chk("acc_req_id", bus.acc_req_id, id);
    chk("acc_slot_c", bus.acc_sigs[(N-1)*WI +: WI], 0);
    @(negedge clk);
    bus.step_valid = 1'b0;
    #1;
  endtask

  // Entered #1 after the negedge on which rsp_valid is expected to be up.
  task automatic collect_rsp(input int hold);
    rsp_t e;
    e = sb[0];
    for (int k = 0; k < hold; k++) begin
      chk("rsp_valid_hold", bus.rsp_valid, 1);
      chk("req_ready_done", bus.req_ready, 0);
      chk("rsp_sig_stable", bus.rsp_sig, e.sig);
      @(negedge clk); #1;
    end
    chk("rsp_valid", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    #1;
    e = sb.pop_front();
    chk("rsp_sig", bus.rsp_sig, e.sig);
    chk("rsp_sticky", bus.rsp_sticky, e.sticky);
    chk("rsp_id", bus.rsp_id, e.id);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    chk("rsp_valid_after", bus.rsp_valid, 0);
    chk("req_ready_after", bus.req_ready, 1);
  endtask

  task automatic run_job(input int len, input logic [WI-1:0] c, input logic cs,
                         input logic [31:0] id, input logic [WI-1:0] prod,
                         input logic [N-2:0] stky, input int hold);
    rsp_t e;
    int rem, take;
    logic [WO-1:0] p;
    p = {{(WO-WI){prod[WI-1]}}, prod};
    e.sig = {{(WO-WI){c[WI-1]}}, c};
    e.sticky = cs;
    e.id = id;
    rem = len;
    while (rem > 0) begin
      take = (rem >= N-1) ? N-1 : rem;
      for (int i = 0; i < take; i++) e.sig = e.sig + p;
      if (|(stky & mask_for(rem))) e.sticky = 1'b1;
      rem -= take;
    end
    sb.push_back(e);
    send_req(len, c, cs, id);
    if (len == 0) chk("step_ready_len0", bus.step_ready, 0);
    rem = len;
    while (rem > 0) begin
      drive_step(prod, stky, mask_for(rem), id);
      rem -= (rem >= N-1) ? N-1 : rem;
    end
    collect_rsp(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = 0; bus.req_len = '0; bus.req_id = '0; bus.req_c = '0;
    bus.req_c_sticky = 0; bus.step_valid = 0; bus.step_sigs = '0;
    bus.step_sticky = '0; bus.rsp_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_step_ready", bus.step_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_sig", bus.rsp_sig, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    // step_valid in IDLE is not acked
    bus.step_valid = 1'b1;
    #1 chk("idle_step_ready", bus.step_ready, 0);
    chk("idle_acc_valid", bus.acc_valid, 0);
    bus.step_valid = 1'b0;

    run_job(8, 26'd10, 1'b0, 32'h11, 26'd1, 4'b0000, 0);          // 18
    run_job(6, 26'd0, 1'b0, 32'h22, 26'd3, 4'b0000, 0);           // 18, tail 0011
    run_job(0, -26'sd5, 1'b1, 32'h33, 26'd0, 4'b0000, 0);         // 0x3FFFFFFB
    run_job(4, 26'd0, 1'b0, 32'h44, 26'h1FFFFFF, 4'b0001, 5);     // held response
    run_job(3, -26'sd5, 1'b0, 32'h55, 26'h3FFFFFF, 4'b1000, 0);   // masked sticky, carry out

    // Flush together with the second step fire: no response, back to IDLE.
    send_req(12, 26'd100, 1'b1, 32'h66);
    drive_step(26'd7, 4'b0000, 4'b1111, 32'h66);
    bus.step_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.step_valid = 1'b0;
    #1;
    chk("flush_req_ready", bus.req_ready, 1);
    chk("flush_step_ready", bus.step_ready, 0);
    repeat (2) begin
      @(negedge clk); #1;
      chk("flush_no_rsp", bus.rsp_valid, 0);
    end
    run_job(4, 26'd0, 1'b0, 32'h77, 26'd2, 4'b0000, 0);           // 8

    // Reset mid-run drops the job entirely.
    send_req(8, 26'd7, 1'b1, 32'h88);
    drive_step(26'd5, 4'b0000, 4'b1111, 32'h88);
    reset_n = 1'b0;
    bus.step_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    #1;
    chk("rstmid_req_ready", bus.req_ready, 1);
    chk("rstmid_acc_valid", bus.acc_valid, 0);
    chk("rstmid_rsp_valid", bus.rsp_valid, 0);
    chk("rstmid_rsp_sig", bus.rsp_sig, 0);
    chk("rstmid_rsp_sticky", bus.rsp_sticky, 0);
    chk("rstmid_rsp_id", bus.rsp_id, 0);
    reset_n = 1'b1;
    flush = 1'b0;
    bus.step_valid = 1'b0;

    // Signed wrap: max positive C plus sixteen max positive products.
    run_job(16, 26'h1FFFFFF, 1'b0, 32'h99, 26'h1FFFFFF, 4'b0000, 0);
    run_job(1, 26'd0, 1'b0, 32'hAA, 26'h3FFFFFF, 4'b0001, 0);      // tail mask 0001

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
